// File: rtl/shared_lane_pkg.sv
// Shared definitions for the shared-lane arbiter: FSM state encoding and default sizing.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package shared_lane_pkg;

  typedef enum logic {LANE_IDLE, LANE_BURST} lane_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 2;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/shared_lane_arbiter_rr_pick.sv
// Cyclic first-valid search: lowest requester index at or after rr_ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick
  import shared_lane_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   pick
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester overwrites last.
  always_comb begin
    any_valid = |req;
    pick      = rr_ptr;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
  end

endmodule

// File: rtl/shared_lane_arbiter.sv
// Round-robin sequencer granting one narrow output lane to one requester per burst.
// Latency: grant one cycle after a request is seen idle; accepted beat visible on out_* next cycle.
// Backpressure: owner's req_ready drops while the output stage is full and out_ready is low.
module shared_lane_arbiter
  import shared_lane_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_owner,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  // beat_cnt value at which the next accepted beat is the last one allowed
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);

  lane_state_e   state, state_nxt;
  logic [OW-1:0] owner, rr_ptr, pick;
  logic [CW-1:0] beat_cnt;
  logic          any_valid, stage_free, accept, burst_end;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .any_valid (any_valid),
    .pick      (pick)
  );

  // The output stage can take a beat when empty or draining this cycle.
  assign stage_free = !out_valid || out_ready;
  assign accept     = (state == LANE_BURST) && req_valid[owner] && stage_free;
  assign burst_end  = accept && (req_last[owner] || (beat_cnt == LAST_BEAT));

  // Next state and per-requester ready; only the owner can ever see ready.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b0;
    case (state)
      LANE_IDLE: begin
        if (any_valid) state_nxt = LANE_BURST;
      end
      LANE_BURST: begin
        busy             = 1'b1;
        req_ready[owner] = stage_free;
        if (burst_end) state_nxt = LANE_IDLE;
      end
      default: state_nxt = LANE_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LANE_IDLE;
    else     state <= state_nxt;
  end

  // Grant capture, beat counting and pointer advance at burst end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else if (state == LANE_IDLE && any_valid) begin
      owner    <= pick;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (burst_end) rr_ptr <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
    end
  end

  // Single registered output stage; a new beat overwrites a draining one without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_owner <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= req_data[owner*DATA_W +: DATA_W];
      out_owner <= owner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
